// File: rtl/rv32i_pkg.sv
// Shared RV32I front-end types and constants.
package rv32i_pkg;

    localparam int          XLEN      = 32;
    localparam logic [31:0] PC_STEP   = 32'd4;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;   // addi x0, x0, 0

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        HOLD  = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/pc_reg.sv
// Program counter: sequential increment, redirect load and word alignment.
module pc_reg
    import rv32i_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            nRst,
    input  logic            inc,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic [XLEN-1:0] pc
);

    localparam logic [XLEN-1:0] ALIGN_MASK = ~32'h0000_0003;

    // Redirect wins over increment; the add wraps naturally at 2^32.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst)         pc <= RESET_PC;
        else if (redirect) pc <= redirect_pc & ALIGN_MASK;
        else if (inc)      pc <= pc + PC_STEP;
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch FSM with a single-entry output register toward decode.
module fetch_unit
    import rv32i_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            nRst,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [XLEN-1:0] imem_rdata,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] instr_pc,
    output logic            instr_valid,
    input  logic            instr_ready,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc
);

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] stale_addr_q;
    logic            take;      // accept returned word into the output register

    pc_reg #(.RESET_PC(RESET_PC)) u_pc (
        .clk         (clk),
        .nRst        (nRst),
        .inc         (take),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .pc          (pc)
    );

    // State register.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next state; redirect overrides everything except an outstanding request.
    always_comb begin
        state_d = state_q;
        take    = 1'b0;
        case (state_q)
            IDLE:  state_d = FETCH;
            FETCH: begin
                if (imem_ack) begin
                    if (!redirect) begin
                        take    = 1'b1;
                        state_d = HOLD;
                    end
                    // ack with redirect: drop the word and refetch at target
                end else if (redirect) begin
                    state_d = DRAIN;
                end
            end
            // Wait out the abandoned request; pc already holds the target.
            DRAIN: if (imem_ack) state_d = FETCH;
            HOLD:  if (redirect || instr_ready) state_d = FETCH;
            default: state_d = IDLE;
        endcase
    end

    // Remember the in-flight address so DRAIN keeps the bus stable.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst)
            stale_addr_q <= RESET_PC;
        else if (state_q == FETCH && redirect && !imem_ack)
            stale_addr_q <= pc;
    end

    // Output register toward decode, loaded only by an unredirected ack.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            instr    <= NOP_INSTR;
            instr_pc <= '0;
        end else if (take) begin
            instr    <= imem_rdata;
            instr_pc <= pc;
        end
    end

    assign imem_req    = (state_q == FETCH) || (state_q == DRAIN);
    assign imem_addr   = (state_q == DRAIN) ? stale_addr_q : pc;
    assign instr_valid = (state_q == HOLD);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit.
`timescale 1ns/1ps
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        nRst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        redirect;
    logic [31:0] redirect_pc;

    int pass_cnt = 0;
    int total_cnt = 0;

    localparam logic [31:0] NOP = 32'h0000_0013;

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk         (clk),
        .nRst        (nRst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .redirect    (redirect),
        .redirect_pc (redirect_pc)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        nRst = 1'b0; imem_ack = 1'b0; imem_rdata = '0; instr_ready = 1'b0;
        redirect = 1'b0; redirect_pc = '0;
        step(); step();
        total_cnt++; if (imem_req !== 1'b0) $display("FAIL reset_req got %b exp 0", imem_req); else pass_cnt++;
        total_cnt++; if (imem_addr !== 32'h0) $display("FAIL reset_addr got %h exp 00000000", imem_addr); else pass_cnt++;
        total_cnt++; if (instr !== NOP) $display("FAIL reset_instr got %h exp %h", instr, NOP); else pass_cnt++;
        total_cnt++; if (instr_pc !== 32'h0) $display("FAIL reset_instr_pc got %h exp 00000000", instr_pc); else pass_cnt++;
        total_cnt++; if (instr_valid !== 1'b0) $display("FAIL reset_valid got %b exp 0", instr_valid); else pass_cnt++;
        nRst = 1'b1;
        step();   // IDLE -> FETCH
        total_cnt++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) $display("FAIL first_req got req=%b addr=%h exp req=1 addr=00000000", imem_req, imem_addr); else pass_cnt++;
    endtask

    // Ack arrives one cycle after each request; decode accepts immediately.
    task automatic test_sequential();
        logic [31:0] data [3] = '{32'h1111_0001, 32'h2222_0002, 32'h3333_0003};
        for (int i = 0; i < 3; i++) begin
            step();   // request held a cycle without ack
            total_cnt++; if (imem_req !== 1'b1 || imem_addr !== 32'(4*i) || instr_valid !== 1'b0)
                $display("FAIL seq_req%0d got req=%b addr=%h v=%b exp req=1 addr=%h v=0", i, imem_req, imem_addr, instr_valid, 32'(4*i)); else pass_cnt++;
            imem_ack = 1'b1; imem_rdata = data[i];
            step();
            imem_ack = 1'b0;
            total_cnt++; if (instr_valid !== 1'b1 || instr !== data[i] || instr_pc !== 32'(4*i))
                $display("FAIL seq_out%0d got v=%b instr=%h pc=%h exp v=1 instr=%h pc=%h", i, instr_valid, instr, instr_pc, data[i], 32'(4*i)); else pass_cnt++;
            total_cnt++; if (imem_req !== 1'b0) $display("FAIL seq_hold_req%0d got %b exp 0", i, imem_req); else pass_cnt++;
            instr_ready = 1'b1;
            step();
            instr_ready = 1'b0;
        end
        total_cnt++; if (imem_req !== 1'b1 || imem_addr !== 32'hC || instr_valid !== 1'b0)
            $display("FAIL seq_next got req=%b addr=%h v=%b exp req=1 addr=0000000c v=0", imem_req, imem_addr, instr_valid); else pass_cnt++;
    endtask

    // Decode stalls three cycles; output must not move and no new request.
    task automatic test_hold_stall();
        imem_ack = 1'b1; imem_rdata = 32'h0010_81B3;
        step();
        imem_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            total_cnt++; if (instr_valid !== 1'b1 || instr !== 32'h0010_81B3 || instr_pc !== 32'hC || imem_req !== 1'b0)
                $display("FAIL stall%0d got v=%b instr=%h pc=%h req=%b exp v=1 instr=001081b3 pc=0000000c req=0", i, instr_valid, instr, instr_pc, imem_req); else pass_cnt++;
            step();
        end
        instr_ready = 1'b1;
        step();
        instr_ready = 1'b0;
        total_cnt++; if (imem_req !== 1'b1 || imem_addr !== 32'h10 || instr_valid !== 1'b0)
            $display("FAIL stall_release got req=%b addr=%h v=%b exp req=1 addr=00000010 v=0", imem_req, imem_addr, instr_valid); else pass_cnt++;
    endtask

    // Redirect while presenting an instruction; target low bits are masked.
    task automatic test_redirect_hold();
        imem_ack = 1'b1; imem_rdata = 32'hAAAA_5555;
        step();
        imem_ack = 1'b0;
        total_cnt++; if (instr_valid !== 1'b1 || instr_pc !== 32'h10)
            $display("FAIL rhold_pre got v=%b pc=%h exp v=1 pc=00000010", instr_valid, instr_pc); else pass_cnt++;
        redirect = 1'b1; redirect_pc = 32'h103;
        step();
        redirect = 1'b0;
        total_cnt++; if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h100)
            $display("FAIL rhold got v=%b req=%b addr=%h exp v=0 req=1 addr=00000100", instr_valid, imem_req, imem_addr); else pass_cnt++;
    endtask

    // Redirect with request outstanding: drain stale ack, then fetch target.
    task automatic test_redirect_fetch();
        redirect = 1'b1; redirect_pc = 32'h40;
        step();
        redirect = 1'b0;
        total_cnt++; if (imem_req !== 1'b1 || imem_addr !== 32'h100 || instr_valid !== 1'b0)
            $display("FAIL drain0 got req=%b addr=%h v=%b exp req=1 addr=00000100 v=0", imem_req, imem_addr, instr_valid); else pass_cnt++;
        step();
        total_cnt++; if (imem_req !== 1'b1 || imem_addr !== 32'h100)
            $display("FAIL drain1 got req=%b addr=%h exp req=1 addr=00000100", imem_req, imem_addr); else pass_cnt++;
        imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        step();
        imem_ack = 1'b0;
        total_cnt++; if (imem_req !== 1'b1 || imem_addr !== 32'h40 || instr_valid !== 1'b0)
            $display("FAIL drain_done got req=%b addr=%h v=%b exp req=1 addr=00000040 v=0", imem_req, imem_addr, instr_valid); else pass_cnt++;
        step();
        total_cnt++; if (instr_valid !== 1'b0 || imem_addr !== 32'h40)
            $display("FAIL drain_nostale got v=%b addr=%h exp v=0 addr=00000040", instr_valid, imem_addr); else pass_cnt++;
        imem_ack = 1'b1; imem_rdata = 32'h1357_9BDF;
        step();
        imem_ack = 1'b0;
        total_cnt++; if (instr_valid !== 1'b1 || instr !== 32'h1357_9BDF || instr_pc !== 32'h40)
            $display("FAIL drain_target got v=%b instr=%h pc=%h exp v=1 instr=13579bdf pc=00000040", instr_valid, instr, instr_pc); else pass_cnt++;
        instr_ready = 1'b1;
        step();
        instr_ready = 1'b0;
        total_cnt++; if (imem_addr !== 32'h44) $display("FAIL drain_next got addr=%h exp 00000044", imem_addr); else pass_cnt++;
    endtask

    // Redirect and ack together in FETCH; then redirect together with ready in HOLD.
    task automatic test_redirect_ack();
        imem_ack = 1'b1; imem_rdata = 32'hBAD0_BAD0; redirect = 1'b1; redirect_pc = 32'h80;
        step();
        imem_ack = 1'b0; redirect = 1'b0;
        total_cnt++; if (imem_req !== 1'b1 || imem_addr !== 32'h80 || instr_valid !== 1'b0)
            $display("FAIL rack got req=%b addr=%h v=%b exp req=1 addr=00000080 v=0", imem_req, imem_addr, instr_valid); else pass_cnt++;
        step();
        total_cnt++; if (instr_valid !== 1'b0 || imem_addr !== 32'h80)
            $display("FAIL rack_hold got v=%b addr=%h exp v=0 addr=00000080", instr_valid, imem_addr); else pass_cnt++;
        imem_ack = 1'b1; imem_rdata = 32'h0000_0093;
        step();
        imem_ack = 1'b0;
        total_cnt++; if (instr_valid !== 1'b1 || instr_pc !== 32'h80 || instr !== 32'h0000_0093)
            $display("FAIL rready_pre got v=%b pc=%h instr=%h exp v=1 pc=00000080 instr=00000093", instr_valid, instr_pc, instr); else pass_cnt++;
        redirect = 1'b1; redirect_pc = 32'h200; instr_ready = 1'b1;
        step();
        redirect = 1'b0; instr_ready = 1'b0;
        total_cnt++; if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h200)
            $display("FAIL rready got v=%b req=%b addr=%h exp v=0 req=1 addr=00000200", instr_valid, imem_req, imem_addr); else pass_cnt++;
    endtask

    // PC wrap at top of memory, then async reset mid-request.
    task automatic test_wrap_and_reset();
        imem_ack = 1'b1; imem_rdata = 32'h0; redirect = 1'b1; redirect_pc = 32'hFFFF_FFFE;
        step();
        redirect = 1'b0;
        total_cnt++; if (imem_addr !== 32'hFFFF_FFFC) $display("FAIL wrap_target got %h exp fffffffc", imem_addr); else pass_cnt++;
        imem_rdata = 32'h00A0_0513;
        step();
        imem_ack = 1'b0;
        total_cnt++; if (instr_valid !== 1'b1 || instr_pc !== 32'hFFFF_FFFC)
            $display("FAIL wrap_out got v=%b pc=%h exp v=1 pc=fffffffc", instr_valid, instr_pc); else pass_cnt++;
        instr_ready = 1'b1;
        step();
        instr_ready = 1'b0;
        total_cnt++; if (imem_req !== 1'b1 || imem_addr !== 32'h0)
            $display("FAIL wrap_next got req=%b addr=%h exp req=1 addr=00000000", imem_req, imem_addr); else pass_cnt++;
        redirect = 1'b1; redirect_pc = 32'h300;
        step();   // DRAIN on 0x0, pc now 0x300
        redirect = 1'b0;
        #2 nRst = 1'b0;
        #1;
        total_cnt++; if (imem_req !== 1'b0 || imem_addr !== 32'h0 || instr_valid !== 1'b0 || instr !== NOP)
            $display("FAIL rst_async got req=%b addr=%h v=%b instr=%h exp req=0 addr=00000000 v=0 instr=00000013", imem_req, imem_addr, instr_valid, instr); else pass_cnt++;
        step();
        nRst = 1'b1;
        imem_ack = 1'b1; imem_rdata = 32'hFACE_FACE;   // stray ack seen in IDLE
        step();
        imem_ack = 1'b0;
        total_cnt++; if (imem_req !== 1'b1 || imem_addr !== 32'h0 || instr_valid !== 1'b0)
            $display("FAIL rst_restart got req=%b addr=%h v=%b exp req=1 addr=00000000 v=0", imem_req, imem_addr, instr_valid); else pass_cnt++;
        step();
        total_cnt++; if (instr_valid !== 1'b0 || imem_req !== 1'b1)
            $display("FAIL rst_stray_ack got v=%b req=%b exp v=0 req=1", instr_valid, imem_req); else pass_cnt++;
        imem_ack = 1'b1; imem_rdata = 32'h0050_0593;
        step();
        imem_ack = 1'b0;
        total_cnt++; if (instr_valid !== 1'b1 || instr !== 32'h0050_0593 || instr_pc !== 32'h0)
            $display("FAIL rst_fetch got v=%b instr=%h pc=%h exp v=1 instr=00500593 pc=00000000", instr_valid, instr, instr_pc); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_hold_stall();
        test_redirect_hold();
        test_redirect_fetch();
        test_redirect_ack();
        test_wrap_and_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the first fetch address after reset.
REQ-002 clk  input  1  the single clock; all state updates on the rising edge.
REQ-003 nRst  input  1  asynchronous, active-low reset.
REQ-004 imem_req  output  1  instruction-memory read request.
REQ-005 imem_addr  output  32  word-aligned fetch address; valid while imem_req=1.
REQ-006 imem_ack  input  1  one-cycle pulse; imem_rdata is valid in the same cycle.
REQ-007 imem_rdata  input  32  fetched instruction word.
REQ-008 instr  output  32  instruction presented to the control unit's instruction input.
REQ-009 instr_pc  output  32  address that instr was fetched from.
REQ-010 instr_valid  output  1  instr and instr_pc are valid.
REQ-011 instr_ready  input  1  decode stage accepts instr this cycle.
REQ-012 redirect  input  1  one-cycle branch or jump redirect.
REQ-013 redirect_pc  input  32  redirect target; bits [1:0] are ignored and treated as 0.

Function
REQ-014 The fetch FSM SHALL have four states:
- IDLE: no request.
- FETCH: imem_req=1, imem_addr=pc.
- DRAIN: imem_req=1, imem_addr=stale address held; returned data is discarded.
- HOLD: instr_valid=1.
REQ-015 IDLE SHALL go to FETCH unconditionally on the next edge.
REQ-016 In FETCH with imem_ack=1 and redirect=0, the block SHALL:
- latch instr<=imem_rdata and instr_pc<=pc;
- set pc<=pc+4;
- enter HOLD.
REQ-017 In FETCH, imem_req and imem_addr SHALL stay constant until imem_ack is seen.
REQ-018 In HOLD, instr, instr_pc and instr_valid SHALL stay stable until instr_ready=1; then the FSM SHALL enter FETCH.
REQ-019 A handshake completes when instr_valid=1 and instr_ready=1 in the same cycle; instr_ready while not valid SHALL have no effect.
REQ-020 Minimum latency SHALL be: imem_ack in cycle N -> instr_valid=1 in cycle N+1; back-to-back throughput is one instruction per 2 cycles with zero-wait memory.
REQ-021 pc+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-022 redirect has highest priority in every state and SHALL set pc<={redirect_pc[31:2],2'b00} and clear instr_valid on the next edge.
REQ-023 Next state on redirect SHALL be:
- from FETCH without ack in the same cycle: DRAIN (the request is outstanding);
- from FETCH with ack in the same cycle: FETCH, with the data discarded;
- from HOLD, IDLE or DRAIN: FETCH (DRAIN keeps draining if its ack has not yet arrived; the new target is still recorded).
REQ-024 In DRAIN, the block SHALL hold imem_addr at the stale address; on imem_ack it SHALL discard imem_rdata and enter FETCH at the redirected pc.
REQ-025 redirect together with instr_ready in HOLD SHALL retire the presented instruction, and the next fetch SHALL use redirect_pc.
REQ-026 instr_valid SHALL never be asserted in FETCH, DRAIN or IDLE.

Reset
REQ-027 While nRst=0, outputs SHALL be:
- state=IDLE, pc=RESET_PC;
- imem_req=0, imem_addr=RESET_PC;
- instr=32'h0000_0013 (NOP), instr_pc=0, instr_valid=0.
REQ-028 Reset asserted mid-transaction SHALL abandon any outstanding request immediately; an imem_ack after reset release while in IDLE SHALL be ignored.

Structure
REQ-029 The shared package rv32i_pkg SHALL hold:
- the fetch_state_t enum (IDLE, FETCH, DRAIN, HOLD);
- XLEN=32, PC_STEP=4, NOP_INSTR=32'h0000_0013.
REQ-030 The PC register, with increment, redirect and alignment masking, SHALL be a sub-module pc_reg; the FSM and output register live in fetch_unit.

Verification
REQ-031 Reset release with RESET_PC=0, ack one cycle after each req -> requests at 0x0, 0x4, 0x8; instr_pc matches each; instr_valid one cycle after each ack.
REQ-032 imem_rdata=32'h0010_81B3 (add) returned, instr_ready held 0 for 3 cycles -> instr stable 3 cycles; no new imem_req until ready=1.
REQ-033 redirect=1, redirect_pc=0x103 in HOLD -> instr_valid=0 next cycle; next imem_addr=0x100.
REQ-034 redirect=1, redirect_pc=0x40 in FETCH, ack 2 cycles later -> imem_addr stays at stale address through DRAIN, data discarded, next request at 0x40, no instr_valid for the stale word.
REQ-035 Redirect and ack in the same FETCH cycle -> data discarded, imem_addr=redirect target next cycle.
REQ-036 Fetch at 0xFFFF_FFFC acked -> next imem_addr=0x0; nRst pulsed low while req outstanding -> imem_req=0 immediately, restart at RESET_PC.
